// File: rtl/dac_pkg.sv
// Shared state encodings, default widths and duty clamping for the PWM DAC driver.
package dac_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int DEFAULT_CODE_WIDTH = 10;

  // Codes above the window length saturate to a fully-high window.
  function automatic logic [31:0] clamp_duty(input logic [31:0] code, input logic [31:0] n);
    return (code > n) ? n : code;
  endfunction

endpackage

// File: rtl/pwm_window_counter.sv
// Window position counter: counts 0..N-1 and wraps while run is high; clear forces it to 0.
module pwm_window_counter #(
  parameter int N     = 1024,
  parameter int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             at_start,
  output logic             at_end
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt      = cnt_q;
  assign at_start = (cnt_q == '0);
  assign at_end   = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_dac_driver.sv
// PWM DAC driver: paces a sample producer with next_sample, latches its code once per window
// and emits a registered PWM stream. Define PWM_CENTER_ALIGNED_EN for center-aligned pulses.
module pwm_dac_driver
  import dac_pkg::*;
#(
  parameter int CYCLES_PER_WINDOW = 1024,
  parameter int CODE_WIDTH        = DEFAULT_CODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  next_sample,
  output logic                  pwm,
  output logic                  active,
  output logic                  clip
);

  localparam int          CNT_W  = $clog2(CYCLES_PER_WINDOW);
  localparam int          DUTY_W = CODE_WIDTH + 1;
  localparam logic [31:0] N      = 32'(CYCLES_PER_WINDOW);

  logic [1:0]        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;
  logic              clip_q, clip_d;
  logic [CNT_W-1:0]  cnt;
  logic              at_start, at_end;
  logic              latch;
  logic [DUTY_W-1:0] code_clamped;
  logic [DUTY_W-1:0] d_sel;

  pwm_window_counter #(
    .N     (CYCLES_PER_WINDOW),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q != ST_IDLE),
    .clear    (state_q == ST_IDLE),
    .cnt      (cnt),
    .at_start (at_start),
    .at_end   (at_end)
  );

  // The first cycle of a running window compares against the fresh code, not the stale duty.
  assign latch        = (state_q == ST_RUN) && at_start;
  assign code_clamped = DUTY_W'(clamp_duty(32'(code), N));
  assign d_sel        = latch ? code_clamped : duty_q;

`ifdef PWM_CENTER_ALIGNED_EN
  logic [31:0] lo;
  assign lo = (N - 32'(d_sel)) >> 1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: if (at_end) state_d = enable ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    duty_d = latch ? code_clamped : duty_q;
    clip_d = latch && (32'(code) > N);
    pwm_d  = 1'b0;
    if (state_q != ST_IDLE) begin
`ifdef PWM_CENTER_ALIGNED_EN
      pwm_d = (32'(cnt) >= lo) && (32'(cnt) < lo + 32'(d_sel));
`else
      pwm_d = 32'(cnt) < 32'(d_sel);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      clip_q  <= clip_d;
    end
  end

  assign next_sample = rst && (state_q == ST_RUN) && at_end;
  assign active      = (state_q != ST_IDLE);
  assign pwm         = pwm_q;
  assign clip        = clip_q;

endmodule

// File: tb/tb_pwm_dac_driver.sv
// Directed bench for pwm_dac_driver with a 16-cycle window; outputs are sampled 1 time unit
// after each rising edge and compared as the packed vector {active, next_sample, pwm, clip}.
module tb_pwm_dac_driver;

  localparam int N  = 16;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CW-1:0] code;
  logic          next_sample, pwm, active, clip;

  int       vectors     = 0;
  int       miscompares = 0;
  logic [3:0] got, want;

  pwm_dac_driver #(
    .CYCLES_PER_WINDOW (N),
    .CODE_WIDTH        (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .code        (code),
    .next_sample (next_sample),
    .pwm         (pwm),
    .active      (active),
    .clip        (clip)
  );

  always #5 clk = ~clk;

  // Expected pwm for a cycle whose previous window position was prev_cnt under the given duty.
  function automatic logic exp_pwm(input int prev_cnt, input int duty);
`ifdef PWM_CENTER_ALIGNED_EN
    int lo;
    lo = (N - duty) / 2;
    return (prev_cnt >= lo) && (prev_cnt < lo + duty);
`else
    return prev_cnt < duty;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    enable = 1'b1;
    code   = CW'(4);
    for (int i = 0; i < 5; i++) begin
      step();
      got  = {active, next_sample, pwm, clip};
      want = 4'b0000;
      vectors++;
      if (got !== want) begin
        $display("FAIL reset i=%0d {act,ns,pwm,clip} got %b want %b", i, got, want);
        miscompares++;
      end
    end
  endtask

  task automatic test_steady();
    rst    = 1'b1;
    enable = 1'b1;
    code   = CW'(4);
    for (int k = 0; k < 3 * N; k++) begin
      step();
      got  = {active, next_sample, pwm, clip};
      want = {1'b1, (k % N) == N - 1, (k == 0) ? 1'b0 : exp_pwm((k - 1) % N, 4), 1'b0};
      vectors++;
      if (got !== want) begin
        $display("FAIL steady k=%0d {act,ns,pwm,clip} got %b want %b", k, got, want);
        miscompares++;
      end
    end
  endtask

  // Window 0 runs code 0, windows 1-2 run code 20 (saturated, clipping).
  task automatic test_extremes();
    int duty, prev;
    code = CW'(0);
    for (int w = 0; w < 3; w++) begin
      duty = (w == 0) ? 0 : N;
      prev = (w == 0) ? 4 : ((w == 1) ? 0 : N);
      for (int c = 0; c < N; c++) begin
        step();
        got  = {active, next_sample, pwm, clip};
        want = {1'b1, c == N - 1, (c == 0) ? exp_pwm(N - 1, prev) : exp_pwm(c - 1, duty),
                (w > 0) && (c == 1)};
        vectors++;
        if (got !== want) begin
          $display("FAIL extremes w=%0d c=%0d {act,ns,pwm,clip} got %b want %b", w, c, got, want);
          miscompares++;
        end
        if (w == 0 && c == N - 1) code = CW'(20);
      end
    end
  endtask

  task automatic test_alternating();
    int duty, prev;
    code = CW'(4);
    for (int w = 0; w < 4; w++) begin
      duty = (w % 2 == 0) ? 4 : 12;
      prev = (w == 0) ? N : ((w % 2 == 1) ? 4 : 12);
      for (int c = 0; c < N; c++) begin
        step();
        got  = {active, next_sample, pwm, clip};
        want = {1'b1, c == N - 1, (c == 0) ? exp_pwm(N - 1, prev) : exp_pwm(c - 1, duty), 1'b0};
        vectors++;
        if (got !== want) begin
          $display("FAIL alternating w=%0d c=%0d {act,ns,pwm,clip} got %b want %b", w, c, got, want);
          miscompares++;
        end
        if (c == N - 1) code = (duty == 4) ? CW'(12) : CW'(4);
      end
    end
  endtask

  task automatic test_enable_drop();
    code = CW'(8);
    for (int c = 0; c < N; c++) begin
      step();
      got  = {active, next_sample, pwm, clip};
      want = {1'b1, 1'b0, (c == 0) ? exp_pwm(N - 1, 12) : exp_pwm(c - 1, 8), 1'b0};
      vectors++;
      if (got !== want) begin
        $display("FAIL enable_drop c=%0d {act,ns,pwm,clip} got %b want %b", c, got, want);
        miscompares++;
      end
      if (c == 7) begin
        enable = 1'b0;
        code   = CW'(2);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      got  = {active, next_sample, pwm, clip};
      want = 4'b0000;
      vectors++;
      if (got !== want) begin
        $display("FAIL drop_idle i=%0d {act,ns,pwm,clip} got %b want %b", i, got, want);
        miscompares++;
      end
    end
  endtask

  // Enable falls during the last cycle of a window: the pulse still fires, then a full drain window.
  task automatic test_back_to_back();
    enable = 1'b1;
    code   = CW'(4);
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < N; c++) begin
        step();
        if (w == 0 && c == N - 1) begin
          enable = 1'b0;
          code   = CW'(9);
          #1;
        end
        got  = {active, next_sample, pwm, clip};
        want = {1'b1, (w == 0) && (c == N - 1),
                (c == 0) ? ((w == 0) ? 1'b0 : exp_pwm(N - 1, 4)) : exp_pwm(c - 1, 4), 1'b0};
        vectors++;
        if (got !== want) begin
          $display("FAIL back_to_back w=%0d c=%0d {act,ns,pwm,clip} got %b want %b", w, c, got, want);
          miscompares++;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      got  = {active, next_sample, pwm, clip};
      want = 4'b0000;
      vectors++;
      if (got !== want) begin
        $display("FAIL b2b_idle i=%0d {act,ns,pwm,clip} got %b want %b", i, got, want);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    code   = CW'(20);
    for (int c = 0; c < 10; c++) begin
      step();
      got  = {active, next_sample, pwm, clip};
      want = {1'b1, 1'b0, (c == 0) ? 1'b0 : exp_pwm(c - 1, N), c == 1};
      vectors++;
      if (got !== want) begin
        $display("FAIL reset_mid_run c=%0d {act,ns,pwm,clip} got %b want %b", c, got, want);
        miscompares++;
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      got  = {active, next_sample, pwm, clip};
      want = 4'b0000;
      vectors++;
      if (got !== want) begin
        $display("FAIL reset_mid_hold i=%0d {act,ns,pwm,clip} got %b want %b", i, got, want);
        miscompares++;
      end
    end
    rst  = 1'b1;
    code = CW'(4);
    for (int k = 0; k <= N; k++) begin
      step();
      got  = {active, next_sample, pwm, clip};
      want = {1'b1, (k % N) == N - 1, (k == 0) ? 1'b0 : exp_pwm((k - 1) % N, 4), 1'b0};
      vectors++;
      if (got !== want) begin
        $display("FAIL reset_mid_restart k=%0d {act,ns,pwm,clip} got %b want %b", k, got, want);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_extremes();
    test_alternating();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
